// File: rtl/ascii_ps2_sender.sv
// Keyboard-side PS/2 emulator: maps one ASCII character to its set-2 make code
// and serialises the keystroke (make, F0, make) on ps2_clk/ps2_data.
module ascii_ps2_sender #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] ascii_in,
    input  logic       valid,
    output logic       ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       unmapped
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int unsigned BIT_W = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FRAME = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [7:0]       code_q, code_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             low_q, low_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             ps2_clk_q, ps2_clk_d;
    logic             ps2_data_q, ps2_data_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             unmapped_q, unmapped_d;

    logic [8:0]       map_c;
    logic [7:0]       cur_byte_c;

    // Inverse set-2 table; returns {mapped, make_code}
    function automatic logic [8:0] map_ascii(input logic [7:0] c);
        case (c)
            8'h30: map_ascii = {1'b1, 8'h45};
            8'h31: map_ascii = {1'b1, 8'h16};
            8'h32: map_ascii = {1'b1, 8'h1E};
            8'h33: map_ascii = {1'b1, 8'h26};
            8'h34: map_ascii = {1'b1, 8'h25};
            8'h35: map_ascii = {1'b1, 8'h2E};
            8'h36: map_ascii = {1'b1, 8'h36};
            8'h37: map_ascii = {1'b1, 8'h3D};
            8'h38: map_ascii = {1'b1, 8'h3E};
            8'h39: map_ascii = {1'b1, 8'h46};
            8'h61: map_ascii = {1'b1, 8'h1C};
            8'h62: map_ascii = {1'b1, 8'h32};
            8'h63: map_ascii = {1'b1, 8'h21};
            8'h64: map_ascii = {1'b1, 8'h23};
            8'h65: map_ascii = {1'b1, 8'h24};
            8'h66: map_ascii = {1'b1, 8'h2B};
            8'h67: map_ascii = {1'b1, 8'h34};
            8'h68: map_ascii = {1'b1, 8'h33};
            8'h69: map_ascii = {1'b1, 8'h43};
            8'h6A: map_ascii = {1'b1, 8'h3B};
            8'h6B: map_ascii = {1'b1, 8'h42};
            8'h6C: map_ascii = {1'b1, 8'h4B};
            8'h6D: map_ascii = {1'b1, 8'h3A};
            8'h6E: map_ascii = {1'b1, 8'h31};
            8'h6F: map_ascii = {1'b1, 8'h44};
            8'h70: map_ascii = {1'b1, 8'h4D};
            8'h71: map_ascii = {1'b1, 8'h15};
            8'h72: map_ascii = {1'b1, 8'h2D};
            8'h73: map_ascii = {1'b1, 8'h1B};
            8'h74: map_ascii = {1'b1, 8'h2C};
            8'h75: map_ascii = {1'b1, 8'h3C};
            8'h76: map_ascii = {1'b1, 8'h2A};
            8'h77: map_ascii = {1'b1, 8'h1D};
            8'h78: map_ascii = {1'b1, 8'h22};
            8'h79: map_ascii = {1'b1, 8'h35};
            8'h7A: map_ascii = {1'b1, 8'h1A};
            8'h27: map_ascii = {1'b1, 8'h52};
            8'h2C: map_ascii = {1'b1, 8'h41};
            8'h2D: map_ascii = {1'b1, 8'h4E};
            8'h2E: map_ascii = {1'b1, 8'h49};
            8'h2F: map_ascii = {1'b1, 8'h4A};
            8'h3B: map_ascii = {1'b1, 8'h4C};
            8'h3D: map_ascii = {1'b1, 8'h55};
            8'h5B: map_ascii = {1'b1, 8'h54};
            8'h5C: map_ascii = {1'b1, 8'h5D};
            8'h5D: map_ascii = {1'b1, 8'h5B};
            8'h60: map_ascii = {1'b1, 8'h0E};
            default: map_ascii = 9'h000;
        endcase
    endfunction

    // Frame bit idx: start 0, data LSB first, odd parity, stop 1
    function automatic logic frame_bit(input logic [7:0] b, input logic [BIT_W-1:0] idx);
        if (idx == 4'd0)      frame_bit = 1'b0;
        else if (idx <= 4'd8) frame_bit = b[3'(idx - 4'd1)];
        else if (idx == 4'd9) frame_bit = ~(^b);
        else                  frame_bit = 1'b1;
    endfunction

    assign map_c      = map_ascii(ascii_in);
    assign cur_byte_c = (byte_idx_q == 2'd1) ? 8'hF0 : code_q;

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        byte_idx_d = byte_idx_q;
        bit_d      = bit_q;
        div_d      = div_q;
        low_d      = low_q;
        gap_d      = gap_q;
        ps2_clk_d  = ps2_clk_q;
        ps2_data_d = ps2_data_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        unmapped_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (valid && ready_q) begin
                    if (map_c[8]) begin
                        code_d     = map_c[7:0];
                        byte_idx_d = 2'd0;
                        bit_d      = '0;
                        div_d      = '0;
                        low_d      = 1'b0;
                        ps2_clk_d  = 1'b1;
                        ps2_data_d = 1'b0;
                        ready_d    = 1'b0;
                        busy_d     = 1'b1;
                        state_d    = S_FRAME;
                    end else begin
                        unmapped_d = 1'b1;
                    end
                end
            end
            S_FRAME: begin
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d = '0;
                    if (!low_q) begin
                        low_d     = 1'b1;
                        ps2_clk_d = 1'b0;
                    end else begin
                        low_d     = 1'b0;
                        ps2_clk_d = 1'b1;
                        if (bit_q == 4'd10) begin
                            gap_d      = '0;
                            ps2_data_d = 1'b1;
                            state_d    = S_GAP;
                        end else begin
                            bit_d      = bit_q + 4'd1;
                            ps2_data_d = frame_bit(cur_byte_c, bit_q + 4'd1);
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    if (byte_idx_q == 2'd2) begin
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        bit_d      = '0;
                        div_d      = '0;
                        low_d      = 1'b0;
                        ps2_data_d = 1'b0;
                        state_d    = S_FRAME;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d    = S_IDLE;
                ps2_clk_d  = 1'b1;
                ps2_data_d = 1'b1;
                ready_d    = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= S_IDLE;
            code_q     <= '0;
            byte_idx_q <= '0;
            bit_q      <= '0;
            div_q      <= '0;
            low_q      <= 1'b0;
            gap_q      <= '0;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            unmapped_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            byte_idx_q <= byte_idx_d;
            bit_q      <= bit_d;
            div_q      <= div_d;
            low_q      <= low_d;
            gap_q      <= gap_d;
            ps2_clk_q  <= ps2_clk_d;
            ps2_data_q <= ps2_data_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            unmapped_q <= unmapped_d;
        end
    end

    assign ready    = ready_q;
    assign busy     = busy_q;
    assign ps2_clk  = ps2_clk_q;
    assign ps2_data = ps2_data_q;
    assign unmapped = unmapped_q;

endmodule

// File: tb/tb_ascii_ps2_sender.sv
// Bench for ascii_ps2_sender: directed keystrokes, a PS/2 line decoder per DUT,
// and a queue of expected bytes popped as each frame is decoded.
module tb_ascii_ps2_sender;

    logic       clk = 1'b0;
    logic       clrn0, clrn1;
    logic [7:0] ascii0, ascii1;
    logic       valid0, valid1;
    logic       ready0, ps2_clk0, ps2_data0, busy0, unmapped0;
    logic       ready1, ps2_clk1, ps2_data1, busy1, unmapped1;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    int         nb[2];
    logic [10:0] sh[2];
    logic       pc[2];
    logic       pd[2];
    int         lastfall[2];

    ascii_ps2_sender #(.CLK_DIV(4), .GAP_CYCLES(16)) u_dut0 (
        .clk(clk), .clrn(clrn0), .ascii_in(ascii0), .valid(valid0), .ready(ready0),
        .ps2_clk(ps2_clk0), .ps2_data(ps2_data0), .busy(busy0), .unmapped(unmapped0)
    );

    ascii_ps2_sender #(.CLK_DIV(2), .GAP_CYCLES(1)) u_dut1 (
        .clk(clk), .clrn(clrn1), .ascii_in(ascii1), .valid(valid1), .ready(ready1),
        .ps2_clk(ps2_clk1), .ps2_data(ps2_data1), .busy(busy1), .unmapped(unmapped1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A complete 11-bit frame was decoded; check framing and pop the expected byte
    task automatic check_frame(input int k, input logic [10:0] f);
        logic [7:0] e;
        tests++;
        if (f[0] !== 1'b0 || f[10] !== 1'b1 || (^f[9:1]) !== 1'b1) begin
            fails++;
            $display("FAIL framing%0d: got frame %b", k, f);
        end
        tests++;
        if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
            fails++;
            $display("FAIL frame_data%0d: got unexpected byte %0h, expected none", k, f[8:1]);
        end else begin
            e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            if (f[8:1] !== e) begin
                fails++;
                $display("FAIL frame_data%0d: got %0h expected %0h", k, f[8:1], e);
            end
        end
    endtask

    // Receiver model: samples data on each falling ps2_clk
    task automatic mon(input int k, input logic rn, input logic c, input logic d, input int div);
        if (!rn) begin
            nb[k] = 0;
            pc[k] = 1'b1;
            pd[k] = 1'b1;
        end else begin
            if (pc[k] && !c) begin
                chk($sformatf("data_stable%0d", k), 32'(d), 32'(pd[k]));
                if (nb[k] > 0) chk($sformatf("bit_period%0d", k), 32'(cyc - lastfall[k]), 32'(2 * div));
                lastfall[k] = cyc;
                sh[k] = {d, sh[k][10:1]};
                nb[k]++;
                if (nb[k] == 11) begin
                    check_frame(k, sh[k]);
                    nb[k] = 0;
                end
            end
            pc[k] = c;
            pd[k] = d;
        end
    endtask

    always @(negedge clk) begin
        mon(0, clrn0, ps2_clk0, ps2_data0, 4);
        mon(1, clrn1, ps2_clk1, ps2_data1, 2);
    end

    task automatic send(input int k, input logic [7:0] ch, input logic [7:0] code,
                        input bit mapped, output int acc);
        int n = 0;
        if (k == 0) begin valid0 = 1'b1; ascii0 = ch; end
        else        begin valid1 = 1'b1; ascii1 = ch; end
        while (((k == 0) ? !ready0 : !ready1) && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) begin
            tests++;
            fails++;
            $display("FAIL send_timeout%0d: got ready=0 expected ready=1 within 2000 cycles", k);
        end
        if (mapped) begin
            if (k == 0) begin exp_q0.push_back(code); exp_q0.push_back(8'hF0); exp_q0.push_back(code); end
            else        begin exp_q1.push_back(code); exp_q1.push_back(8'hF0); exp_q1.push_back(code); end
        end
        tick();
        acc = cyc;
        if (k == 0) valid0 = 1'b0;
        else        valid1 = 1'b0;
    endtask

    task automatic wait_ready(input int k);
        int n = 0;
        while (((k == 0) ? !ready0 : !ready1) && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout%0d: got ready=0 expected ready=1 within 5000 cycles", k);
        end
    endtask

    logic [7:0] chars [47] = '{
        8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
        8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69, 8'h6A,
        8'h6B, 8'h6C, 8'h6D, 8'h6E, 8'h6F, 8'h70, 8'h71, 8'h72, 8'h73, 8'h74,
        8'h75, 8'h76, 8'h77, 8'h78, 8'h79, 8'h7A,
        8'h27, 8'h2C, 8'h2D, 8'h2E, 8'h2F, 8'h3B, 8'h3D, 8'h5B, 8'h5C, 8'h5D, 8'h60
    };
    logic [7:0] codes [47] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
        8'h52, 8'h41, 8'h4E, 8'h49, 8'h4A, 8'h4C, 8'h55, 8'h54, 8'h5D, 8'h5B, 8'h0E
    };

    initial begin
        int a0, a1, a2;
        clrn0 = 1'b0; clrn1 = 1'b0;
        valid0 = 1'b0; valid1 = 1'b0;
        ascii0 = 8'h00; ascii1 = 8'h00;
        repeat (3) tick();

        // Reset state
        chk("rst_ready", 32'(ready0), 1);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_clk", 32'(ps2_clk0), 1);
        chk("rst_data", 32'(ps2_data0), 1);
        chk("rst_unmapped", 32'(unmapped0), 0);
        chk("rst_ready1", 32'(ready1), 1);
        clrn0 = 1'b1; clrn1 = 1'b1;
        tick();

        // 'a' at defaults: latency, first fall, 312-cycle keystroke, valid ignored while busy
        send(0, 8'h61, 8'h1C, 1'b1, a0);
        chk("start_data", 32'(ps2_data0), 0);
        chk("start_clk", 32'(ps2_clk0), 1);
        chk("start_busy", 32'(busy0), 1);
        chk("start_ready", 32'(ready0), 0);
        valid0 = 1'b1; ascii0 = 8'h62;
        repeat (3) tick();
        chk("pre_fall_clk", 32'(ps2_clk0), 1);
        tick();
        chk("first_fall_clk", 32'(ps2_clk0), 0);
        repeat (50) tick();
        valid0 = 1'b0;
        wait_ready(0);
        chk("ready_low_cycles", 32'(cyc - a0), 312);
        chk("busy_after", 32'(busy0), 0);
        tick();
        chk("drain_a", 32'(exp_q0.size()), 0);

        // Unmapped characters: one-cycle pulse, nothing else moves
        send(0, 8'h41, 8'h00, 1'b0, a1);
        chk("unm_A_pulse", 32'(unmapped0), 1);
        chk("unm_A_ready", 32'(ready0), 1);
        chk("unm_A_lines", 32'({ps2_clk0, ps2_data0}), 3);
        tick();
        chk("unm_A_clear", 32'(unmapped0), 0);
        send(0, 8'h00, 8'h00, 1'b0, a1);
        chk("unm_00_pulse", 32'(unmapped0), 1);
        chk("unm_00_ready", 32'(ready0), 1);
        tick();
        chk("unm_00_clear", 32'(unmapped0), 0);
        chk("unm_00_lines", 32'({ps2_clk0, ps2_data0, ready0}), 7);

        // Back-to-back 'q' then '1': second accepted the cycle ready rises
        send(0, 8'h71, 8'h15, 1'b1, a1);
        send(0, 8'h31, 8'h16, 1'b1, a2);
        chk("b2b_accept_gap", 32'(a2 - a1), 313);
        wait_ready(0);
        tick();
        chk("drain_b2b", 32'(exp_q0.size()), 0);

        // Full table back to back
        for (int i = 0; i < 47; i++) send(0, chars[i], codes[i], 1'b1, a1);
        wait_ready(0);
        tick();
        chk("drain_table", 32'(exp_q0.size()), 0);

        // Reset during bit 5 of the F0 frame aborts at once
        send(0, 8'h61, 8'h1C, 1'b1, a0);
        repeat (146) tick();
        chk("pre_abort_busy", 32'(busy0), 1);
        clrn0 = 1'b0;
        #1;
        chk("abort_clk", 32'(ps2_clk0), 1);
        chk("abort_data", 32'(ps2_data0), 1);
        chk("abort_ready", 32'(ready0), 1);
        chk("abort_busy", 32'(busy0), 0);
        exp_q0.delete();
        repeat (2) tick();
        clrn0 = 1'b1;
        repeat (300) tick();
        chk("abort_quiet", 32'({ps2_clk0, ps2_data0, ready0}), 7);
        send(0, 8'h7A, 8'h1A, 1'b1, a0);
        wait_ready(0);
        chk("z_ready_low_cycles", 32'(cyc - a0), 312);
        tick();
        chk("drain_z", 32'(exp_q0.size()), 0);

        // Minimum parameters: 4-cycle bits, 135-cycle keystroke
        send(1, 8'h61, 8'h1C, 1'b1, a0);
        chk("min_start_data", 32'(ps2_data1), 0);
        wait_ready(1);
        chk("min_ready_low_cycles", 32'(cyc - a0), 135);
        tick();
        chk("drain_min", 32'(exp_q1.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
